// File: rtl/pipe_pkg.sv
// Shared types and constants for the 16-bit pipeline: operand-mux select codes,
// the per-stage destination record, and the forwarding match rule.
package pipe_pkg;

  localparam int unsigned RA_W = 4;

  localparam logic [1:0] SEL_REG = 2'b11;
  localparam logic [1:0] SEL_ALU = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b00;

  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] dst;
    logic            wr;
    logic            load;
  } stage_rec_t;

  localparam stage_rec_t REC_BUBBLE = '0;

  // Register 0 is hardwired, so a write to it never produces a forwardable value.
  function automatic logic rec_hit(stage_rec_t rec, logic [RA_W-1:0] src);
    return rec.valid && rec.wr && (rec.dst == src) && (src != '0);
  endfunction

endpackage

// File: rtl/fwd_sel_calc.sv
// Per-operand forwarding select: the EX producer beats the MEM producer, and the
// register-file operand is used when neither stage writes the source.
module fwd_sel_calc
  import pipe_pkg::*;
(
  input  logic [RA_W-1:0] src,
  input  stage_rec_t      ex_rec,
  input  stage_rec_t      mem_rec,
  output logic [1:0]      sel
);

  always_comb begin
    sel = SEL_REG;
    if (rec_hit(ex_rec, src)) begin
      sel = SEL_ALU;
    end else if (rec_hit(mem_rec, src)) begin
      sel = SEL_WB;
    end
  end

  // The load flag only matters for hazard detection in the parent.
  logic unused_load;
  assign unused_load = ex_rec.load | mem_rec.load;

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller: tracks EX/MEM destinations, registers
// the EX operand-mux selects, and stalls ID for one cycle on a load-use dependency.
module fwd_hazard_ctrl #(
  parameter int unsigned RA_W  = pipe_pkg::RA_W,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid_i,
  input  logic [RA_W-1:0]  id_src1_i,
  input  logic [RA_W-1:0]  id_src2_i,
  input  logic [RA_W-1:0]  id_dst_i,
  input  logic             id_wr_en_i,
  input  logic             id_is_load_i,
  input  logic             flush_i,
  input  logic             hold_i,
  output logic [1:0]       sel_op1_o,
  output logic [1:0]       sel_op2_o,
  output logic             ex_valid_o,
  output logic             stall_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  import pipe_pkg::*;

  stage_rec_t       ex_q;
  stage_rec_t       mem_q;
  stage_rec_t       id_rec;
  logic [1:0]       sel1_q, sel1_d;
  logic [1:0]       sel2_q, sel2_d;
  logic [CNT_W-1:0] cnt_q;
  logic             load_use;
  logic             issue;

  always_comb begin
    id_rec       = REC_BUBBLE;
    id_rec.valid = 1'b1;
    id_rec.dst   = id_dst_i;
    id_rec.wr    = id_wr_en_i;
    id_rec.load  = id_is_load_i;
  end

  // Only an EX-stage load is too late to forward; a MEM-stage load forwards from WB.
  assign load_use = id_valid_i && ex_q.load &&
                    (rec_hit(ex_q, id_src1_i) || rec_hit(ex_q, id_src2_i));

  assign stall_o = load_use && !flush_i && !hold_i;
  assign issue   = id_valid_i && !stall_o && !flush_i;

  fwd_sel_calc u_sel_op1 (
    .src     (id_src1_i),
    .ex_rec  (ex_q),
    .mem_rec (mem_q),
    .sel     (sel1_d)
  );

  fwd_sel_calc u_sel_op2 (
    .src     (id_src2_i),
    .ex_rec  (ex_q),
    .mem_rec (mem_q),
    .sel     (sel2_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q   <= REC_BUBBLE;
      mem_q  <= REC_BUBBLE;
      sel1_q <= SEL_REG;
      sel2_q <= SEL_REG;
      cnt_q  <= '0;
    end else if (!hold_i) begin
      mem_q <= ex_q;
      if (issue) begin
        ex_q   <= id_rec;
        sel1_q <= sel1_d;
        sel2_q <= sel2_d;
      end else begin
        ex_q   <= REC_BUBBLE;
        sel1_q <= SEL_REG;
        sel2_q <= SEL_REG;
      end
      if (stall_o && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign sel_op1_o   = sel1_q;
  assign sel_op2_o   = sel2_q;
  assign ex_valid_o  = ex_q.valid;
  assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl; a second narrow-counter instance shares the
// stimulus so counter saturation is reachable in a short run.
module tb_fwd_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [3:0]  id_src1, id_src2, id_dst;
  logic        id_wr_en, id_is_load, flush, hold;
  logic [1:0]  sel_op1, sel_op2;
  logic        ex_valid, stall;
  logic [15:0] stall_cnt;
  logic [1:0]  s_sel_op1, s_sel_op2;
  logic        s_ex_valid, s_stall;
  logic [3:0]  s_stall_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.RA_W(4), .CNT_W(16)) dut (
    .clk (clk), .rst_n (rst_n), .id_valid_i (id_valid), .id_src1_i (id_src1),
    .id_src2_i (id_src2), .id_dst_i (id_dst), .id_wr_en_i (id_wr_en),
    .id_is_load_i (id_is_load), .flush_i (flush), .hold_i (hold),
    .sel_op1_o (sel_op1), .sel_op2_o (sel_op2), .ex_valid_o (ex_valid),
    .stall_o (stall), .stall_cnt_o (stall_cnt)
  );

  fwd_hazard_ctrl #(.RA_W(4), .CNT_W(4)) dut_small (
    .clk (clk), .rst_n (rst_n), .id_valid_i (id_valid), .id_src1_i (id_src1),
    .id_src2_i (id_src2), .id_dst_i (id_dst), .id_wr_en_i (id_wr_en),
    .id_is_load_i (id_is_load), .flush_i (flush), .hold_i (hold),
    .sel_op1_o (s_sel_op1), .sel_op2_o (s_sel_op2), .ex_valid_o (s_ex_valid),
    .stall_o (s_stall), .stall_cnt_o (s_stall_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                       input logic [3:0] d, input logic wr, input logic ld);
    id_valid = v; id_src1 = s1; id_src2 = s2; id_dst = d; id_wr_en = wr; id_is_load = ld;
    #1;
  endtask

  task automatic drain();
    drive(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; hold = 1'b0;
    drive(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    #3;
    rst_n = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({sel_op1, sel_op2} !== 4'b1111) begin
      n_fail++; $display("FAIL reset_sel: got %b/%b want 11/11", sel_op1, sel_op2);
    end
    n_cmp++;
    if (ex_valid !== 1'b0 || stall !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid_stall: got %b/%b want 0/0", ex_valid, stall);
    end
    n_cmp++;
    if (stall_cnt !== 16'd0) begin
      n_fail++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt);
    end
  endtask

  task automatic test_fwd_ex();
    drive(1'b1, 4'd1, 4'd2, 4'd3, 1'b1, 1'b0);   // ADD r3,r1,r2
    tick();
    n_cmp++;
    if ({sel_op1, sel_op2} !== 4'b1111 || ex_valid !== 1'b1) begin
      n_fail++; $display("FAIL add_in_ex: got sel %b/%b v %b want 11/11 v 1",
                         sel_op1, sel_op2, ex_valid);
    end
    drive(1'b1, 4'd3, 4'd4, 4'd5, 1'b1, 1'b0);   // SUB r5,r3,r4
    n_cmp++;
    if (stall !== 1'b0) begin
      n_fail++; $display("FAIL sub_no_stall: got %b want 0", stall);
    end
    tick();
    n_cmp++;
    if (sel_op1 !== 2'b01 || sel_op2 !== 2'b11) begin
      n_fail++; $display("FAIL fwd_from_ex: got %b/%b want 01/11", sel_op1, sel_op2);
    end
    drain();
  endtask

  task automatic test_fwd_mem();
    drive(1'b1, 4'd1, 4'd2, 4'd3, 1'b1, 1'b0);   // ADD r3
    tick();
    drive(1'b1, 4'd9, 4'd10, 4'd8, 1'b1, 1'b0);  // unrelated r8
    tick();
    drive(1'b1, 4'd2, 4'd3, 4'd6, 1'b1, 1'b0);   // OR r6,r2,r3
    tick();
    n_cmp++;
    if (sel_op1 !== 2'b11 || sel_op2 !== 2'b00) begin
      n_fail++; $display("FAIL fwd_from_mem: got %b/%b want 11/00", sel_op1, sel_op2);
    end
    drain();
    // Two producers of r3 in a row: EX copy must win over MEM copy.
    drive(1'b1, 4'd1, 4'd2, 4'd3, 1'b1, 1'b0);
    tick();
    drive(1'b1, 4'd4, 4'd5, 4'd3, 1'b1, 1'b0);
    tick();
    drive(1'b1, 4'd3, 4'd3, 4'd7, 1'b1, 1'b0);
    tick();
    n_cmp++;
    if (sel_op1 !== 2'b01 || sel_op2 !== 2'b01) begin
      n_fail++; $display("FAIL newest_wins: got %b/%b want 01/01", sel_op1, sel_op2);
    end
    drain();
  endtask

  task automatic test_load_use();
    drive(1'b1, 4'd1, 4'd0, 4'd2, 1'b1, 1'b1);   // LOAD r2
    tick();
    drive(1'b1, 4'd2, 4'd2, 4'd7, 1'b1, 1'b0);   // ADD r7,r2,r2
    n_cmp++;
    if (stall !== 1'b1) begin
      n_fail++; $display("FAIL lu_stall: got %b want 1", stall);
    end
    tick();
    n_cmp++;
    if (ex_valid !== 1'b0 || stall !== 1'b0 || stall_cnt !== 16'd1) begin
      n_fail++; $display("FAIL lu_bubble: got v %b stall %b cnt %0d want 0 0 1",
                         ex_valid, stall, stall_cnt);
    end
    tick();
    n_cmp++;
    if (sel_op1 !== 2'b00 || sel_op2 !== 2'b00 || ex_valid !== 1'b1) begin
      n_fail++; $display("FAIL lu_issue: got %b/%b v %b want 00/00 v 1",
                         sel_op1, sel_op2, ex_valid);
    end
    drain();
  endtask

  task automatic test_flush();
    drive(1'b1, 4'd1, 4'd0, 4'd2, 1'b1, 1'b1);
    tick();
    flush = 1'b1;
    drive(1'b1, 4'd2, 4'd2, 4'd7, 1'b1, 1'b0);
    n_cmp++;
    if (stall !== 1'b0) begin
      n_fail++; $display("FAIL flush_stall: got %b want 0", stall);
    end
    tick();
    flush = 1'b0;
    drive(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    n_cmp++;
    if (ex_valid !== 1'b0 || stall_cnt !== 16'd1) begin
      n_fail++; $display("FAIL flush_bubble: got v %b cnt %0d want 0 1", ex_valid, stall_cnt);
    end
    drain();
  endtask

  task automatic test_hold();
    drive(1'b1, 4'd1, 4'd0, 4'd2, 1'b1, 1'b1);
    tick();
    hold = 1'b1;
    drive(1'b1, 4'd2, 4'd2, 4'd7, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (stall !== 1'b0 || ex_valid !== 1'b1 || {sel_op1, sel_op2} !== 4'b1111 ||
          stall_cnt !== 16'd1) begin
        n_fail++; $display("FAIL hold_frozen[%0d]: got st %b v %b sel %b/%b cnt %0d",
                           i, stall, ex_valid, sel_op1, sel_op2, stall_cnt);
      end
      tick();
    end
    hold = 1'b0;
    #1;
    n_cmp++;
    if (stall !== 1'b1) begin
      n_fail++; $display("FAIL hold_release_stall: got %b want 1", stall);
    end
    tick();
    n_cmp++;
    if (ex_valid !== 1'b0 || stall_cnt !== 16'd2) begin
      n_fail++; $display("FAIL hold_bubble: got v %b cnt %0d want 0 2", ex_valid, stall_cnt);
    end
    tick();
    n_cmp++;
    if (sel_op1 !== 2'b00 || sel_op2 !== 2'b00) begin
      n_fail++; $display("FAIL hold_issue: got %b/%b want 00/00", sel_op1, sel_op2);
    end
    drain();
  endtask

  task automatic test_r0();
    drive(1'b1, 4'd1, 4'd2, 4'd0, 1'b1, 1'b0);   // write r0
    tick();
    drive(1'b1, 4'd0, 4'd0, 4'd5, 1'b1, 1'b0);   // read r0,r0
    tick();
    n_cmp++;
    if (sel_op1 !== 2'b11 || sel_op2 !== 2'b11) begin
      n_fail++; $display("FAIL r0_ex: got %b/%b want 11/11", sel_op1, sel_op2);
    end
    drain();
    drive(1'b1, 4'd1, 4'd0, 4'd0, 1'b1, 1'b1);   // LOAD r0
    tick();
    drive(1'b1, 4'd0, 4'd0, 4'd5, 1'b1, 1'b0);
    n_cmp++;
    if (stall !== 1'b0) begin
      n_fail++; $display("FAIL r0_load_stall: got %b want 0", stall);
    end
    tick();
    n_cmp++;
    if (sel_op1 !== 2'b11 || sel_op2 !== 2'b11 || stall_cnt !== 16'd2) begin
      n_fail++; $display("FAIL r0_load_sel: got %b/%b cnt %0d want 11/11 2",
                         sel_op1, sel_op2, stall_cnt);
    end
    drain();
  endtask

  task automatic test_saturate();
    // LOAD r2 <- [r2] repeated: every other edge is a load-use stall.
    drive(1'b1, 4'd2, 4'd2, 4'd2, 1'b1, 1'b1);
    tick();
    for (int i = 0; i < 20; i++) begin
      tick();
      tick();
    end
    drive(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    n_cmp++;
    if (stall_cnt !== 16'd22) begin
      n_fail++; $display("FAIL cnt_wide: got %0d want 22", stall_cnt);
    end
    n_cmp++;
    if (s_stall_cnt !== 4'hF) begin
      n_fail++; $display("FAIL cnt_saturate: got %h want f", s_stall_cnt);
    end
    drain();
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b1, 4'd1, 4'd0, 4'd2, 1'b1, 1'b1);
    tick();
    drive(1'b1, 4'd2, 4'd2, 4'd7, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (stall !== 1'b0 || ex_valid !== 1'b0 || stall_cnt !== 16'd0 ||
        {sel_op1, sel_op2} !== 4'b1111) begin
      n_fail++; $display("FAIL reset_mid_stall: got st %b v %b cnt %0d sel %b/%b",
                         stall, ex_valid, stall_cnt, sel_op1, sel_op2);
    end
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (stall !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_stall: got %b want 0", stall);
    end
    tick();
    n_cmp++;
    if (ex_valid !== 1'b1 || stall_cnt !== 16'd0) begin
      n_fail++; $display("FAIL post_reset_issue: got v %b cnt %0d want 1 0",
                         ex_valid, stall_cnt);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_fwd_ex();
    test_fwd_mem();
    test_load_use();
    test_flush();
    test_hold();
    test_r0();
    test_saturate();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
